// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: debounced button commands over switch operands, one op in flight
// C multiply (shift-add), U leading ones, D popcount, L add, R signed subtract.
module seq_alu #(
  parameter int BITS      = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] SW,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  output logic [BITS-1:0] LED,
  output logic            busy,
  output logic            valid
);

  localparam int H   = BITS / 2;
  localparam int CW  = $clog2(BITS + 1);
  localparam int DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {OP_MUL, OP_CLO, OP_POP, OP_ADD, OP_SUB} op_t;

  logic [4:0]     btn_raw;
  logic [4:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]     db_q, db_d, edge_q, edge_d;
  logic [DBW-1:0] db_cnt_q [5];
  logic [DBW-1:0] db_cnt_d [5];

  state_t          state_q, state_d;
  op_t             op_q, op_d, cmd_op;
  logic [BITS-1:0] scan_q, scan_d, mcand_q, mcand_d, acc_q, acc_d, led_q, led_d;
  logic [CW-1:0]   cnt_q, cnt_d, last_cnt;
  logic            ones_q, ones_d, busy_q, busy_d, valid_q, valid_d;
  logic [H-1:0]    op_a, op_b;

  assign btn_raw = {BTNC, BTNU, BTND, BTNL, BTNR};
  assign op_a    = scan_q[BITS-1:H];
  assign op_b    = scan_q[H-1:0];
  assign LED     = led_q;
  assign busy    = busy_q;
  assign valid   = valid_q;

  // A level is accepted once DB_CYCLES consecutive synchronised samples disagree with it.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    edge_d  = '0;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
          db_d[i]   = sync2_q[i];
          edge_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    cmd_op = OP_MUL;
    if (edge_q[4])      cmd_op = OP_MUL;
    else if (edge_q[3]) cmd_op = OP_CLO;
    else if (edge_q[2]) cmd_op = OP_POP;
    else if (edge_q[1]) cmd_op = OP_ADD;
    else                cmd_op = OP_SUB;
  end

  always_comb begin
    case (op_q)
      OP_MUL:         last_cnt = CW'(H - 1);
      OP_CLO, OP_POP: last_cnt = CW'(BITS - 1);
      default:        last_cnt = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    scan_d  = scan_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    led_d   = led_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|edge_q) begin
          op_d    = cmd_op;
          scan_d  = SW;
          mcand_d = {{H{1'b0}}, SW[BITS-1:H]};
          acc_d   = '0;
          cnt_d   = '0;
          ones_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        case (op_q)
          OP_MUL: begin
            if (scan_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            scan_d  = scan_q >> 1;
          end
          OP_CLO: begin
            if (ones_q && scan_q[BITS-1]) acc_d = acc_q + BITS'(1);
            else                          ones_d = 1'b0;
            scan_d = scan_q << 1;
          end
          OP_POP: begin
            if (scan_q[BITS-1]) acc_d = acc_q + BITS'(1);
            scan_d = scan_q << 1;
          end
          OP_ADD:  acc_d = {{H{1'b0}}, op_a} + {{H{1'b0}}, op_b};
          OP_SUB:  acc_d = {{H{op_a[H-1]}}, op_a} - {{H{op_b[H-1]}}, op_b};
          default: acc_d = acc_q;
        endcase
        if (cnt_q == last_cnt) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        led_d   = acc_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      edge_q  <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      scan_q  <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ones_q  <= 1'b0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      edge_q  <= edge_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q <= state_d;
      op_q    <= op_d;
      scan_q  <= scan_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter BITS, default 16, operand/LED width; SHALL be even and >= 4.
REQ-002 Parameter DB_CYCLES, default 4, consecutive stable samples required to accept a button level.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SW  input  BITS  operand switches: A = SW[BITS-1:BITS/2], B = SW[BITS/2-1:0].
REQ-006 BTNC, BTNU, BTND, BTNL, BTNR  input  1 each  raw asynchronous push buttons (command requests).
REQ-007 LED  output  BITS  last completed result, registered.
REQ-008 busy  output  1  high while an operation is executing.
REQ-009 valid  output  1  one-cycle pulse when LED is updated.

Function
REQ-010 Each button SHALL pass through a 2-flop synchroniser, then a debouncer whose output changes only after DB_CYCLES consecutive equal synchronised samples.
REQ-011 A command SHALL be a 0->1 edge of a debounced button; a held button SHALL issue one command only.
REQ-012 Simultaneous command edges SHALL resolve by priority C > U > D > L > R; lower-priority edges in that cycle SHALL be dropped.
REQ-013 Operations: C = A*B unsigned, full BITS result; U = count of leading ones of SW from MSB (0..BITS); D = popcount of SW (0..BITS); L = A+B unsigned, zero-extended; R = signed(A) - signed(B), sign-extended to BITS.
REQ-014 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: on a command, SW and opcode SHALL be captured into internal registers in that cycle and the FSM SHALL move to RUN; busy SHALL be high from the next cycle.
REQ-016 RUN: C SHALL execute as serial shift-add, one multiplier bit per cycle, BITS/2 cycles; U and D SHALL scan one SW bit per cycle, MSB first, BITS cycles (U stops counting at first zero but still takes BITS cycles); L and R SHALL take 1 cycle.
REQ-017 DONE: LED SHALL load the result, valid SHALL pulse for exactly one cycle, busy SHALL drop, and the FSM SHALL return to IDLE in the same cycle; total acceptance-to-valid latency = N+1 cycles (N per REQ-016).
REQ-018 Command edges arriving while busy=1 or in DONE SHALL be discarded, not queued.
REQ-019 SW changes after capture SHALL NOT affect the running operation.
REQ-020 LED SHALL hold its value between completions; valid SHALL never be high while busy is high.
REQ-021 Arithmetic SHALL wrap modulo 2^BITS only where stated (R sign-extension); C cannot overflow BITS.

Reset
REQ-022 rst_n low SHALL asynchronously force LED = 0, busy = 0, valid = 0, FSM = IDLE, synchroniser, debouncer and counter state = 0.
REQ-023 Reset asserted during RUN SHALL abort the operation with no valid pulse and LED = 0.
REQ-024 After rst_n deasserts, a button already held high SHALL produce exactly one command once debounced.

Verification (BITS=16, DB_CYCLES=4)
REQ-025 SW=0x0C0A, press BTNC -> busy for 8 cycles, then LED=0x0078, single valid pulse; SW=0xFFFF, BTNC -> LED=0xFE01.
REQ-026 SW=0x0C0A, BTNL -> LED=0x0016 after 2 cycles; SW=0x0A0C, BTNR -> LED=0xFFFE.
REQ-027 SW=0xF0F1, BTND -> LED=0x0009 after 17 cycles; BTNU -> LED=0x0004; SW=0xFFFF, BTNU -> LED=0x0010; SW=0x0000, BTNU -> LED=0x0000.
REQ-028 BTNU high for 3 cycles (< DB_CYCLES) -> no command, busy stays 0; BTNC and BTNL edges same cycle -> only multiply runs.
REQ-029 BTNC during RUN of BTND, and SW changed mid-RUN -> only popcount of captured SW reported, no second operation.
REQ-030 rst_n pulsed low mid-multiply -> LED=0, busy=0, no valid; held BTNC through reset -> exactly one multiply afterwards.
